// File: rtl/switch_pkg.sv
// switch_conditioner shared types and constants.
// Repeat FSM states, parameter defaults and SWI bit roles.
package switch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } rpt_state_t;

  localparam int DEF_NSW           = 8;
  localparam int DEF_DEBOUNCE      = 4;
  localparam int DEF_REPEAT_DELAY  = 8;
  localparam int DEF_REPEAT_PERIOD = 4;

  localparam int SW_RESET    = 0;
  localparam int SW_UP       = 1;
  localparam int SW_ON       = 2;
  localparam int SW_LOAD     = 3;
  localparam int SW_DATA_LSB = 4;

endpackage

// File: rtl/switch_conditioner_if.sv
// switch_conditioner bus: raw switches in, conditioned
// levels and pulses out.
interface switch_conditioner_if #(
  parameter int NSW = 8
);

  logic [NSW-1:0] SWI;
  logic [NSW-1:0] sw_level;
  logic [NSW-1:0] sw_rise;
  logic [NSW-1:0] sw_fall;
  logic [NSW-1:0] sw_press;

  modport master (
    output SWI,
    input  sw_level,
    input  sw_rise,
    input  sw_fall,
    input  sw_press
  );

  modport slave (
    input  SWI,
    output sw_level,
    output sw_rise,
    output sw_fall,
    output sw_press
  );

endinterface

// File: rtl/switch_debounce_bit.sv
// One switch bit: 2-flop sync, debounce, edge pulses
// and optional auto-repeat of the press pulse.
module switch_debounce_bit
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk_2,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ?
    REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);

  localparam logic [CW-1:0] DB_LAST =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST =
    RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST =
    RW'(REPEAT_PERIOD - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          flip;
  logic          level_nxt;
  rpt_state_t    state;
  logic [RW-1:0] rcnt;

  // Level flips once s2 has disagreed for the full window.
  always_comb begin
    flip      = (s2 != level) && (cnt == DB_LAST);
    level_nxt = flip ? s2 : level;
  end

  // Synchroniser, debounce counter, level and edge pulses.
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      unique case (1'b1)
        (s2 == level), flip: cnt <= '0;
        default:             cnt <= cnt + 1'b1;
      endcase
      level <= level_nxt;
      rise  <= flip & s2;
      fall  <= flip & ~s2;
    end
  end

  // Press on rise, then delayed and periodic repeats.
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rcnt  <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (!level_nxt) begin
        state <= IDLE;
        rcnt  <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (flip) begin
              press <= 1'b1;
              rcnt  <= '0;
              state <= REPEAT_EN ? HOLD : IDLE;
            end
          end
          HOLD: begin
            if (rcnt == DLY_LAST) begin
              press <= 1'b1;
              rcnt  <= '0;
              state <= REPEAT;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          REPEAT: begin
            if (rcnt == PER_LAST) begin
              press <= 1'b1;
              rcnt  <= '0;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            rcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/switch_conditioner.sv
// Conditions raw board switches into clean levels,
// edge pulses and auto-repeating press pulses.
module switch_conditioner
  import switch_pkg::*;
#(
  parameter int             NSW             = DEF_NSW,
  parameter int             DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter logic [NSW-1:0] REPEAT_MASK     = '0,
  parameter int             REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int             REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input logic                 clk_2,
  input logic                 reset,
  switch_conditioner_if.slave bus
);

  logic [NSW-1:0] level;
  logic [NSW-1:0] rise;
  logic [NSW-1:0] fall;
  logic [NSW-1:0] press;

  for (genvar i = 0; i < NSW; i++) begin : g_bit
    switch_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_EN       (REPEAT_MASK[i]),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_bit (
      .clk_2 (clk_2),
      .reset (reset),
      .raw   (bus.SWI[i]),
      .level (level[i]),
      .rise  (rise[i]),
      .fall  (fall[i]),
      .press (press[i])
    );
  end

  assign bus.sw_level = level;
  assign bus.sw_rise  = rise;
  assign bus.sw_fall  = fall;
  assign bus.sw_press = press;

endmodule

// File: tb/tb_switch_conditioner.sv
// switch_conditioner bench: random and directed switch
// patterns against a window-based reference model.
module tb_switch_conditioner;

  localparam int NSW = 8;
  localparam int DB  = 4;
  localparam int RD  = 8;
  localparam int RP  = 4;
  localparam logic [NSW-1:0] RM = 8'h02;

  typedef struct packed {
    logic [NSW-1:0] level;
    logic [NSW-1:0] rise;
    logic [NSW-1:0] fall;
    logic [NSW-1:0] press;
  } obs_t;

  logic clk_2;
  logic reset;

  switch_conditioner_if #(.NSW(NSW)) bus ();

  switch_conditioner #(
    .NSW             (NSW),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_MASK     (RM),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  obs_t           exp_q[$];
  logic [NSW-1:0] smp[$];
  logic [NSW-1:0] m_level;
  int             t_edge;
  int             rise_t[NSW];
  logic [NSW-1:0] cur;

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  function automatic obs_t actual();
    obs_t a;
    a.level = bus.sw_level;
    a.rise  = bus.sw_rise;
    a.fall  = bus.sw_fall;
    a.press = bus.sw_press;
    return a;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h",
               name, act, req);
    end
  endtask

  // Reference model: a bit flips when the synchronised
  // input (SWI two edges back) has differed from the level
  // on each of the last DB edges since reset.
  initial begin
    m_level = '0;
    t_edge  = 0;
    forever begin
      @(posedge clk_2 or negedge reset);
      if (!reset) begin
        smp.delete();
        exp_q.delete();
        m_level = '0;
        t_edge  = 0;
      end else begin
        obs_t e;
        e = '0;
        smp.push_back(bus.SWI);
        for (int b = 0; b < NSW; b++) begin
          logic flip;
          int   dt;
          flip = (t_edge - DB + 1) >= 0;
          for (int j = t_edge - DB + 1; j <= t_edge; j++) begin
            logic [NSW-1:0] w;
            if (j < 2) w = '0;
            else       w = smp[j-2];
            if (j >= 0 && w[b] == m_level[b]) flip = 1'b0;
          end
          if (flip) begin
            m_level[b] = ~m_level[b];
            if (m_level[b]) begin
              e.rise[b] = 1'b1;
              rise_t[b] = t_edge;
            end else begin
              e.fall[b] = 1'b1;
            end
          end
          if (RM[b]) begin
            dt = t_edge - rise_t[b];
            e.press[b] = m_level[b] &&
              (dt == 0 ||
               (dt >= RD && ((dt - RD) % RP) == 0));
          end else begin
            e.press[b] = e.rise[b];
          end
        end
        e.level = m_level;
        exp_q.push_back(e);
        t_edge++;
      end
    end
  end

  // Monitor: compares DUT outputs with the model each cycle.
  initial begin
    forever begin
      @(negedge clk_2);
      if (!reset) begin
        check("reset_outputs", 32'(actual()), 32'h0);
      end else if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard_empty: got outputs %h, expected a model entry",
                 actual());
      end else begin
        obs_t e;
        e = exp_q.pop_front();
        check("cycle_outputs", 32'(actual()), 32'(e));
      end
    end
  end

  task automatic drive(input logic [NSW-1:0] v,
                       input int n);
    cur     = v;
    bus.SWI = v;
    repeat (n) @(negedge clk_2);
    #1;
  endtask

  initial begin
    reset   = 1'b0;
    cur     = '0;
    bus.SWI = '0;
    repeat (3) @(negedge clk_2);
    #2 reset = 1'b1;

    drive(8'h00, 4);
    drive(8'h08, 12);
    drive(8'h00, 10);
    drive(8'h01, 1);
    drive(8'h00, 1);
    drive(8'h01, 1);
    drive(8'h00, 1);
    drive(8'h01, 12);
    drive(8'h00, 10);
    drive(8'h04, 3);
    drive(8'h00, 10);
    drive(8'h02, 40);
    drive(8'h00, 15);
    drive(8'hF2, 22);

    @(posedge clk_2);
    #2 reset = 1'b0;
    #1 check("async_clear", 32'(actual()), 32'h0);
    cur     = 8'hF0;
    bus.SWI = 8'hF0;
    repeat (2) @(negedge clk_2);
    #2 reset = 1'b1;
    repeat (5) @(posedge clk_2);
    #1 check("no_rise_before_6", 32'(bus.sw_rise), 32'h0);
    @(posedge clk_2);
    #1 check("rise_after_6", 32'(bus.sw_rise), 32'hF0);
    check("level_after_6", 32'(bus.sw_level), 32'hF0);
    @(negedge clk_2);
    #1;

    drive(8'h00, 15);
    drive(8'hFF, 15);
    drive(8'h00, 15);

    for (int it = 0; it < 250; it++) begin
      logic [NSW-1:0] v;
      if ($urandom_range(0, 1) == 1) begin
        v = NSW'($urandom);
      end else begin
        v = cur;
        v[$urandom_range(0, NSW - 1)] ^= 1'b1;
      end
      drive(v, $urandom_range(1, 14));
    end
    drive(8'h00, 12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
